mmio_dev_ctrl: RTL and testbench
================================

Name: mmio_dev_ctrl

Overview:
- Parametrised memory-mapped I/O controller for the pipelined CPU's MEM stage.
- Replaces the ad-hoc HEX/LEDR/KEY logic with proper devices:
  - HEX and LEDR output registers.
  - KEY and SW input devices with 2-flop synchronisers, sticky ready/overrun status, SW debounce and interrupt enables.
  - Prescaled interval timer.
- Combinational read path, single-cycle writes; sel tells the CPU to mux rdata instead of D-MEM.

Parameters:
- DBITS, 32, data/address width.
- BASE, 32'hFFFFF000, base of the device window.
- HEXBITS, 24, HEX register width.
- LEDRBITS, 10, LEDR register width.
- KEYBITS, 4, key count.
- SWBITS, 10, switch count.
- HEX_RST, 24'hFEDEAD, HEX reset value.
- DEBOUNCE_CYC, 100000, stable cycles required before an SW change is accepted (>=1).
- TICK_CYC, 50000, clk cycles per timer tick (>=1).

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- addr, in, DBITS, byte address from MEM stage.
- wr_en, in, 1, store this cycle.
- wdata, in, DBITS, store data.
- rd_en, in, 1, load this cycle; gates read side effects.
- rdata, out, DBITS, combinational read data.
- sel, out, 1, addr hits a mapped register.
- key_n, in, KEYBITS, raw keys, active-low.
- sw, in, SWBITS, raw switches.
- hex, out, HEXBITS, HEX register.
- ledr, out, LEDRBITS, LEDR register.
- irq, out, 1, OR over devices of (ready & IE), registered.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Register map (offsets from BASE):
  - HEX 0x000, RW.
  - LEDR 0x020, RW.
  - KDATA 0x080, R.
  - KCTRL 0x084, RW.
  - SDATA 0x090, R.
  - SCTRL 0x094, RW.
  - TCNT 0x100, RW.
  - TLIM 0x104, RW.
  - TCTRL 0x108, RW.
- Any other address: sel=0, rdata=0, writes ignored.
- CTRL layout (all devices): bit0 ready, bit2 overrun, bit4 IE; other bits read 0.
- CTRL write semantics:
  - Writing 0 to bit0 or bit2 clears that bit; writing 1 is ignored.
  - IE is written directly.
- Reset values:
  - hex=HEX_RST; ledr=0; irq=0.
  - KDATA=0, SDATA=0, TCNT=0, TLIM=0, TCTRL=0.
  - All ready, overrun and IE bits = 0; prescaler=0; synchronisers=0.
- Writes: take effect at the clk edge when wr_en; narrower registers take wdata LSBs.
- Reads: rdata is zero-extended and valid in the same cycle.
- KEY device:
  - key_n is inverted, then synchronised (2 flops).
  - When the synced value != KDATA, KDATA updates next edge and ready sets; if ready is already 1, overrun sets instead of being lost.
  - Reading KDATA (rd_en && addr==KDATA) clears ready at that edge.
- SW device:
  - Synchronised (2 flops), then candidate register plus counter.
  - Any change of synced value reloads candidate and zeroes the counter.
  - While candidate != SDATA, the counter increments.
  - On reaching DEBOUNCE_CYC-1, SDATA<=candidate, ready sets (overrun if already set), counter zeroes.
  - Reading SDATA clears ready.
- Timer:
  - Prescaler counts 0..TICK_CYC-1; each wrap is one tick.
  - On tick with TLIM!=0 and TCNT==TLIM-1: TCNT<=0, ready sets (overrun if already set).
  - Otherwise TCNT increments mod 2^DBITS.
  - TLIM==0: free-run, never sets ready.
- Simultaneous events:
  - A hardware set beats a software clear in the same cycle.
  - A software write to TCNT beats a tick and also zeroes the prescaler.
  - Writing TLIM does not touch TCNT.
- irq is registered from next-state status: it asserts 1 cycle after the enabling event.
- Reset mid-operation: every register, including debounce and prescaler counters, returns to its reset value immediately; no pending events survive.

Decomposition:
- Package mmio_pkg:
  - Register offsets.
  - CTRL bit positions (RDY=0, OVR=2, IE=4).
  - Window decode helper constant.
- One sub-module, mmio_sync_debounce (parameters WIDTH, CYC): synchroniser plus debounce, outputs stable vector and a 1-cycle change strobe.
- The KEY path uses the same block instantiated with CYC=1 (equivalent to no debounce).

Test Plan:
- Reset → hex=24'hFEDEAD, ledr=0, irq=0; read TCTRL → 0; read 0x00C → sel=0, rdata=0.
- Write HEX=0x123456, LEDR=0x3FF → hex=0x123456, ledr=0x3FF next cycle; read back both same-cycle.
- KEY: set KCTRL=0x10, drive key_n=4'b1110 → KDATA=0x1 and ready within 3 cycles, irq=1. Release before reading → overrun=1. Read KDATA → ready=0, irq=0.
- SW (DEBOUNCE_CYC=4): glitch sw=0x001 for 2 cycles → SDATA stays 0. Hold 0x001 → SDATA=0x001 after sync+4 cycles, ready=1.
- Timer (TICK_CYC=2): TLIM=3, TCTRL=0x10 → TCNT sequence 0,1,2,0, ready and irq set at wrap. Write TCTRL=0 the same cycle as the next wrap → ready stays 1.
- Timer edge: TLIM=0 and TCNT=0xFFFFFFFF → wraps to 0 with no ready. Write TCNT=5 coincident with a tick → TCNT=5.

Source files
------------

// File: rtl/mmio_pkg.sv
// Purpose: shared register map, CTRL bit positions and address decode for the MMIO device controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mmio_pkg;

  // The device window is 4 KiB. Only the low WIN_BITS bits of the offset select a register.
  localparam int WIN_BITS = 12;

  localparam logic [WIN_BITS-1:0] OFF_HEX   = 12'h000;
  localparam logic [WIN_BITS-1:0] OFF_LEDR  = 12'h020;
  localparam logic [WIN_BITS-1:0] OFF_KDATA = 12'h080;
  localparam logic [WIN_BITS-1:0] OFF_KCTRL = 12'h084;
  localparam logic [WIN_BITS-1:0] OFF_SDATA = 12'h090;
  localparam logic [WIN_BITS-1:0] OFF_SCTRL = 12'h094;
  localparam logic [WIN_BITS-1:0] OFF_TCNT  = 12'h100;
  localparam logic [WIN_BITS-1:0] OFF_TLIM  = 12'h104;
  localparam logic [WIN_BITS-1:0] OFF_TCTRL = 12'h108;

  // Bit positions inside every device CTRL register.
  localparam int CTRL_RDY = 0;
  localparam int CTRL_OVR = 2;
  localparam int CTRL_IE  = 4;

  typedef enum logic [3:0] {
    REG_NONE,
    REG_HEX,
    REG_LEDR,
    REG_KDATA,
    REG_KCTRL,
    REG_SDATA,
    REG_SCTRL,
    REG_TCNT,
    REG_TLIM,
    REG_TCTRL
  } reg_e;

  // Maps an in-window offset to a register. Offsets that are not exact hits select nothing.
  function automatic reg_e decode_off(input logic [WIN_BITS-1:0] off);
    reg_e r;
    case (off)
      OFF_HEX:   r = REG_HEX;
      OFF_LEDR:  r = REG_LEDR;
      OFF_KDATA: r = REG_KDATA;
      OFF_KCTRL: r = REG_KCTRL;
      OFF_SDATA: r = REG_SDATA;
      OFF_SCTRL: r = REG_SCTRL;
      OFF_TCNT:  r = REG_TCNT;
      OFF_TLIM:  r = REG_TLIM;
      OFF_TCTRL: r = REG_TCTRL;
      default:   r = REG_NONE;
    endcase
    return r;
  endfunction

  // Packs device status into the low bits of a CTRL read. All other bits read as 0.
  function automatic logic [4:0] ctrl_word(input logic rdy, input logic ovr, input logic ie);
    logic [4:0] w;
    w           = '0;
    w[CTRL_RDY] = rdy;
    w[CTRL_OVR] = ovr;
    w[CTRL_IE]  = ie;
    return w;
  endfunction

endpackage

// File: rtl/mmio_sync_debounce.sv
// Purpose: 2-flop synchroniser followed by an optional debounce filter (CYC stable cycles).
// Latency: CYC==1 -> stable updates 3 edges after din changes; CYC>1 -> 3+CYC edges.
// Backpressure: none; chg is a 1-cycle combinational strobe high in the cycle before stable updates.
// Ports: clk, reset (async, active-high); din raw input; stable is the filtered vector; chg is the update strobe.
module mmio_sync_debounce #(
  parameter int WIDTH = 1,
  parameter int CYC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             chg
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  generate
    if (CYC <= 1) begin : g_direct
      // With no debounce, any synced change is accepted at the next edge.
      assign chg = (s2 != stable);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stable <= '0;
        end else if (chg) begin
          stable <= s2;
        end
      end
    end else begin : g_debounce
      localparam int CW = $clog2(CYC);
      localparam logic [CW-1:0] CNT_LAST = CW'(CYC - 1);

      logic [WIDTH-1:0] cand;
      logic [CW-1:0]    cnt;

      // The candidate must be unchanged this cycle, differ from stable, and have aged CYC cycles.
      assign chg = (s2 == cand) && (cand != stable) && (cnt == CNT_LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cand   <= '0;
          cnt    <= '0;
          stable <= '0;
        end else if (s2 != cand) begin
          // Any movement of the synced input restarts the stability window.
          cand <= s2;
          cnt  <= '0;
        end else if (cand != stable) begin
          if (cnt == CNT_LAST) begin
            stable <= cand;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mmio_dev_ctrl.sv
// Purpose: MMIO controller for the MEM stage: HEX/LEDR outputs, KEY/SW inputs with status, interval timer.
// Latency: reads combinational (same cycle); writes and status updates take effect at the next clk edge; irq 1 cycle.
// Backpressure: none; every access completes in one cycle, sel tells the CPU to take rdata over D-MEM.
// Ports: clk, reset (async, active-high); addr/wr_en/wdata/rd_en/rdata/sel bus side;
//        key_n (active-low) and sw raw inputs; hex/ledr registered outputs; irq registered interrupt.
module mmio_dev_ctrl
  import mmio_pkg::*;
#(
  parameter int                  DBITS        = 32,
  parameter logic [DBITS-1:0]    BASE         = 32'hFFFFF000,
  parameter int                  HEXBITS      = 24,
  parameter int                  LEDRBITS     = 10,
  parameter int                  KEYBITS      = 4,
  parameter int                  SWBITS       = 10,
  parameter logic [HEXBITS-1:0]  HEX_RST      = 24'hFEDEAD,
  parameter int                  DEBOUNCE_CYC = 100000,
  parameter int                  TICK_CYC     = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DBITS-1:0]    addr,
  input  logic                wr_en,
  input  logic [DBITS-1:0]    wdata,
  input  logic                rd_en,
  output logic [DBITS-1:0]    rdata,
  output logic                sel,
  input  logic [KEYBITS-1:0]  key_n,
  input  logic [SWBITS-1:0]   sw,
  output logic [HEXBITS-1:0]  hex,
  output logic [LEDRBITS-1:0] ledr,
  output logic                irq
);

  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);

  // ---------------- address decode ----------------
  logic [DBITS-1:0] off;
  logic             in_win;
  reg_e             rsel;

  assign off    = addr - BASE;
  assign in_win = (off[DBITS-1:WIN_BITS] == '0);
  assign rsel   = in_win ? decode_off(off[WIN_BITS-1:0]) : REG_NONE;
  assign sel    = (rsel != REG_NONE);

  logic wr_hex, wr_ledr, wr_kctrl, wr_sctrl, wr_tcnt, wr_tlim, wr_tctrl;
  logic rd_kdata, rd_sdata;

  assign wr_hex   = wr_en && (rsel == REG_HEX);
  assign wr_ledr  = wr_en && (rsel == REG_LEDR);
  assign wr_kctrl = wr_en && (rsel == REG_KCTRL);
  assign wr_sctrl = wr_en && (rsel == REG_SCTRL);
  assign wr_tcnt  = wr_en && (rsel == REG_TCNT);
  assign wr_tlim  = wr_en && (rsel == REG_TLIM);
  assign wr_tctrl = wr_en && (rsel == REG_TCTRL);
  assign rd_kdata = rd_en && (rsel == REG_KDATA);
  assign rd_sdata = rd_en && (rsel == REG_SDATA);

  // ---------------- input devices ----------------
  logic [KEYBITS-1:0] kdata;
  logic               k_ev;
  logic [SWBITS-1:0]  sdata;
  logic               s_ev;

  mmio_sync_debounce #(.WIDTH(KEYBITS), .CYC(1)) u_key (
    .clk    (clk),
    .reset  (reset),
    .din    (~key_n),
    .stable (kdata),
    .chg    (k_ev)
  );

  mmio_sync_debounce #(.WIDTH(SWBITS), .CYC(DEBOUNCE_CYC)) u_sw (
    .clk    (clk),
    .reset  (reset),
    .din    (sw),
    .stable (sdata),
    .chg    (s_ev)
  );

  // ---------------- state ----------------
  logic             k_rdy, k_ovr, k_ie;
  logic             s_rdy, s_ovr, s_ie;
  logic             t_rdy, t_ovr, t_ie;
  logic [DBITS-1:0] tcnt, tlim;
  logic [PW-1:0]    presc;

  // Software clears are applied first, then a hardware event overrides them, so a set
  // landing on the same edge as a clear is never lost.
  function automatic logic [2:0] stat_next(
    input logic             rdy,
    input logic             ovr,
    input logic             ie,
    input logic             ev,
    input logic             rd_clr,
    input logic             ctrl_wr,
    input logic [DBITS-1:0] wd
  );
    logic n_rdy, n_ovr, n_ie;
    n_rdy = rdy;
    n_ovr = ovr;
    n_ie  = ie;
    if (ctrl_wr) begin
      if (!wd[CTRL_RDY]) n_rdy = 1'b0;
      if (!wd[CTRL_OVR]) n_ovr = 1'b0;
      n_ie = wd[CTRL_IE];
    end
    if (rd_clr) n_rdy = 1'b0;
    if (ev) begin
      if (rdy) n_ovr = 1'b1;
      n_rdy = 1'b1;
    end
    return {n_ie, n_ovr, n_rdy};
  endfunction

  // ---------------- timer next state ----------------
  logic             tick;
  logic             t_ev;
  logic [DBITS-1:0] tcnt_n;
  logic [PW-1:0]    presc_n;

  assign tick = (presc == PRESC_LAST);

  always_comb begin
    tcnt_n  = tcnt;
    presc_n = tick ? '0 : presc + PW'(1);
    t_ev    = 1'b0;
    if (wr_tcnt) begin
      // A software load wins over a coincident tick and restarts the prescale period.
      tcnt_n  = wdata;
      presc_n = '0;
    end else if (tick) begin
      if ((tlim != '0) && (tcnt == tlim - DBITS'(1))) begin
        tcnt_n = '0;
        t_ev   = 1'b1;
      end else begin
        tcnt_n = tcnt + DBITS'(1);
      end
    end
  end

  logic [2:0] k_nxt, s_nxt, t_nxt;
  logic       irq_n;

  assign k_nxt = stat_next(k_rdy, k_ovr, k_ie, k_ev, rd_kdata, wr_kctrl, wdata);
  assign s_nxt = stat_next(s_rdy, s_ovr, s_ie, s_ev, rd_sdata, wr_sctrl, wdata);
  assign t_nxt = stat_next(t_rdy, t_ovr, t_ie, t_ev, 1'b0,     wr_tctrl, wdata);

  // irq follows next-state status so it lines up with the edge that raises ready.
  assign irq_n = (k_nxt[0] & k_nxt[2]) | (s_nxt[0] & s_nxt[2]) | (t_nxt[0] & t_nxt[2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex   <= HEX_RST;
      ledr  <= '0;
      irq   <= 1'b0;
      k_rdy <= 1'b0;
      k_ovr <= 1'b0;
      k_ie  <= 1'b0;
      s_rdy <= 1'b0;
      s_ovr <= 1'b0;
      s_ie  <= 1'b0;
      t_rdy <= 1'b0;
      t_ovr <= 1'b0;
      t_ie  <= 1'b0;
      tcnt  <= '0;
      tlim  <= '0;
      presc <= '0;
    end else begin
      if (wr_hex)  hex  <= wdata[HEXBITS-1:0];
      if (wr_ledr) ledr <= wdata[LEDRBITS-1:0];
      if (wr_tlim) tlim <= wdata;
      tcnt  <= tcnt_n;
      presc <= presc_n;
      {k_ie, k_ovr, k_rdy} <= k_nxt;
      {s_ie, s_ovr, s_rdy} <= s_nxt;
      {t_ie, t_ovr, t_rdy} <= t_nxt;
      irq <= irq_n;
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    rdata = '0;
    case (rsel)
      REG_HEX:   rdata[HEXBITS-1:0]  = hex;
      REG_LEDR:  rdata[LEDRBITS-1:0] = ledr;
      REG_KDATA: rdata[KEYBITS-1:0]  = kdata;
      REG_KCTRL: rdata[4:0]          = ctrl_word(k_rdy, k_ovr, k_ie);
      REG_SDATA: rdata[SWBITS-1:0]   = sdata;
      REG_SCTRL: rdata[4:0]          = ctrl_word(s_rdy, s_ovr, s_ie);
      REG_TCNT:  rdata               = tcnt;
      REG_TLIM:  rdata               = tlim;
      REG_TCTRL: rdata[4:0]          = ctrl_word(t_rdy, t_ovr, t_ie);
      default:   rdata               = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_dev_ctrl.sv
// Purpose: self-checking bench for mmio_dev_ctrl; expected read results are queued as loads are issued
//          and compared when the load's read data is sampled.
// Latency: reads sampled mid-cycle on the falling edge; outputs checked 1 time unit after the rising edge.
// Backpressure: none.
module tb_mmio_dev_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wdata;
  logic        rd_en;
  logic [31:0] rdata;
  logic        sel;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [23:0] hex;
  logic [9:0]  ledr;
  logic        irq;

  localparam logic [31:0] B       = 32'hFFFFF000;
  localparam logic [31:0] A_HEX   = B + 32'h000;
  localparam logic [31:0] A_LEDR  = B + 32'h020;
  localparam logic [31:0] A_KDATA = B + 32'h080;
  localparam logic [31:0] A_KCTRL = B + 32'h084;
  localparam logic [31:0] A_SDATA = B + 32'h090;
  localparam logic [31:0] A_SCTRL = B + 32'h094;
  localparam logic [31:0] A_TCNT  = B + 32'h100;
  localparam logic [31:0] A_TLIM  = B + 32'h104;
  localparam logic [31:0] A_TCTRL = B + 32'h108;

  mmio_dev_ctrl #(
    .DEBOUNCE_CYC (4),
    .TICK_CYC     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wr_en (wr_en),
    .wdata (wdata),
    .rd_en (rd_en),
    .rdata (rdata),
    .sel   (sel),
    .key_n (key_n),
    .sw    (sw),
    .hex   (hex),
    .ledr  (ledr),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: {sel, rdata} expected for each issued load, in issue order.
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [63:0] sb_exp;
  string       sb_tag;

  always @(negedge clk) begin
    if (!reset && rd_en) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        sb_tag = tag_q.pop_front();
        chk(sb_tag, {31'b0, sel, rdata}, sb_exp);
      end
    end
  end

  // Every task is entered 1 unit after a rising edge and returns 1 unit after the next one.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd_x(input string tag, input logic [31:0] a, input logic s, input logic [31:0] d);
    addr  = a;
    rd_en = 1'b1;
    exp_q.push_back({31'b0, s, d});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] d);
    rd_x(tag, a, 1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    addr  = '0;
    wr_en = 1'b0;
    wdata = '0;
    rd_en = 1'b0;
    key_n = 4'hF;
    sw    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hex",  {40'b0, hex},  {40'b0, 24'hFEDEAD});
    chk("rst_ledr", {54'b0, ledr}, 64'd0);
    chk("rst_irq",  {63'b0, irq},  64'd0);
    reset = 1'b0;

    // Reset values and decode.
    rd("rst_tctrl", A_TCTRL, 32'h0);
    rd_x("unmapped_00c", B + 32'h00C, 1'b0, 32'h0);
    rd_x("outside_win", 32'h0000_0000, 1'b0, 32'h0);

    // Output registers.
    wr(A_HEX, 32'hAB12_3456);
    chk("hex_wr", {40'b0, hex}, {40'b0, 24'h123456});
    wr(A_LEDR, 32'hFFFF_FFFF);
    chk("ledr_wr", {54'b0, ledr}, {54'b0, 10'h3FF});
    wr(B + 32'h00C, 32'h0);
    chk("hex_unmapped_wr", {40'b0, hex}, {40'b0, 24'h123456});
    rd("hex_rb", A_HEX, 32'h0012_3456);
    rd("ledr_rb", A_LEDR, 32'h0000_03FF);

    // KEY device.
    wr(A_KCTRL, 32'h10);
    key_n = 4'b1110;
    idle(3);
    chk("key_irq_set", {63'b0, irq}, 64'd1);
    rd("kctrl_rdy", A_KCTRL, 32'h11);
    key_n = 4'b1111;
    idle(3);
    rd("kctrl_ovr", A_KCTRL, 32'h15);
    rd("kdata_rel", A_KDATA, 32'h0);
    chk("key_irq_clr", {63'b0, irq}, 64'd0);
    rd("kctrl_after_rd", A_KCTRL, 32'h14);
    key_n = 4'b0101;
    idle(3);
    rd("kdata_a", A_KDATA, 32'hA);
    wr(A_KCTRL, 32'h15);
    rd("kctrl_w1_ignored", A_KCTRL, 32'h14);
    wr(A_KCTRL, 32'h00);
    rd("kctrl_cleared", A_KCTRL, 32'h0);
    key_n = 4'hF;
    idle(4);

    // SW device: a 2-cycle glitch is rejected, a held value is accepted.
    wr(A_SCTRL, 32'h10);
    rd("sdata_pre", A_SDATA, 32'h0);
    sw = 10'h001;
    idle(2);
    sw = 10'h000;
    idle(10);
    rd("sdata_glitch", A_SDATA, 32'h0);
    rd("sctrl_glitch", A_SCTRL, 32'h10);
    sw = 10'h001;
    idle(12);
    rd("sctrl_rdy", A_SCTRL, 32'h11);
    chk("sw_irq_set", {63'b0, irq}, 64'd1);
    rd("sdata_held", A_SDATA, 32'h1);
    chk("sw_irq_clr", {63'b0, irq}, 64'd0);
    rd("sctrl_after_rd", A_SCTRL, 32'h10);

    // Timer with limit 3.
    wr(A_TLIM, 32'd3);
    wr(A_TCNT, 32'd0);
    wr(A_TCTRL, 32'h10);
    rd("tcnt_0", A_TCNT, 32'd0);
    idle(1);
    rd("tcnt_1", A_TCNT, 32'd1);
    idle(1);
    rd("tcnt_2", A_TCNT, 32'd2);
    chk("tmr_irq_set", {63'b0, irq}, 64'd1);
    rd("tctrl_wrap", A_TCTRL, 32'h11);
    rd("tcnt_wrap0", A_TCNT, 32'd0);
    idle(3);
    wr(A_TCTRL, 32'h0);
    rd("tctrl_set_beats_clr", A_TCTRL, 32'h05);
    chk("tmr_irq_ie_off", {63'b0, irq}, 64'd0);

    // Timer free-run wrap and load-vs-tick priority.
    wr(A_TLIM, 32'd0);
    wr(A_TCTRL, 32'h0);
    wr(A_TCNT, 32'hFFFF_FFFF);
    rd("tcnt_max", A_TCNT, 32'hFFFF_FFFF);
    idle(1);
    rd("tcnt_wrap_free", A_TCNT, 32'd0);
    rd("tctrl_free_norm", A_TCTRL, 32'h0);
    idle(1);
    wr(A_TCNT, 32'd5);
    rd("tcnt_load", A_TCNT, 32'd5);
    rd("tcnt_load_hold", A_TCNT, 32'd5);
    rd("tcnt_after_load", A_TCNT, 32'd6);
    rd("tlim_rb", A_TLIM, 32'd0);

    // Reset mid-operation, with KEY overrun and HEX/LEDR non-default.
    wr(A_KCTRL, 32'h10);
    key_n = 4'b1110;
    idle(4);
    key_n = 4'b1111;
    idle(4);
    reset = 1'b1;
    #2;
    chk("mid_rst_hex",  {40'b0, hex},  {40'b0, 24'hFEDEAD});
    chk("mid_rst_ledr", {54'b0, ledr}, 64'd0);
    chk("mid_rst_irq",  {63'b0, irq},  64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd("post_rst_tcnt", A_TCNT, 32'd0);
    rd("post_rst_kctrl", A_KCTRL, 32'h0);
    rd("post_rst_sdata", A_SDATA, 32'h0);
    rd("post_rst_tlim", A_TLIM, 32'h0);
    idle(2);

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
